keypad_scanner: RTL

Matrix-keypad front end for the alarm clock, sitting between the 4x3 telephone keypad and the clock's 4-bit `key` input. It scans the columns and synchronises the row returns. It decodes a single pressed digit, debounces it over whole scan frames and presents it as the clock's key code: 0-9 for a digit, 4'hA (NOKEY) otherwise. A one-cycle strobe marks each newly accepted digit.

---
 rtl/keypad_scanner.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Front end for a 4x3 telephone keypad. It walks the three columns, samples the
// synchronised rows at the end of each column slot, and decodes one scan frame
// into a single digit code. The frame code is debounced over whole frames and
// presented as a clean key code.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-high reset
//   row_in     keypad rows, active-low, asynchronous to clock
//   col_out    column drive, one-hot active-low, 3'b111 = idle
//   key        debounced key code, 0-9 or 4'hA (no key)
//   key_valid  one-cycle pulse when key is updated to a digit
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_COUNT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [2:0] col_out,
  output logic [3:0] key,
  output logic       key_valid
);

  localparam int SET_W = $clog2(SETTLE_CYCLES);
  localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DEBOUNCE_COUNT);

  localparam logic [1:0] COL0 = 2'd0;
  localparam logic [1:0] COL1 = 2'd1;
  localparam logic [1:0] COL2 = 2'd2;

  localparam logic [3:0] NOKEY = 4'hA;

  // Map an intersection index (row*3 + col) to its key code; '*' and '#'
  // decode as no key.
  function automatic logic [3:0] digit_of(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'h4;
      4'd4:    code = 4'h5;
      4'd5:    code = 4'h6;
      4'd6:    code = 4'h7;
      4'd7:    code = 4'h8;
      4'd8:    code = 4'h9;
      4'd10:   code = 4'h0;
      default: code = NOKEY;
    endcase
    return code;
  endfunction

  logic [3:0]       row_s1_q, row_s2_q;
  logic             run_q;
  logic [1:0]       state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [3:0]       hit0_q, hit1_q;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_q, key_d;
  logic             key_valid_q, key_valid_d;

  logic             slot_end, frame_end;
  logic [11:0]      act;
  logic [3:0]       n_act;
  logic [3:0]       frame_code;
  logic [2:0]       col_pat;

  // run_q holds the columns idle for the first cycle after reset, so that the
  // first driven cycle of COL0 is a full settle slot.
  assign slot_end  = run_q && (settle_q == SETTLE_LAST);
  assign frame_end = slot_end && (state_q == COL2);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (run_q) begin
      if (settle_q == SETTLE_LAST) begin
        settle_d = '0;
        case (state_q)
          COL0:    state_d = COL1;
          COL1:    state_d = COL2;
          default: state_d = COL0;
        endcase
      end else begin
        settle_d = settle_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (state_q)
      COL0:    col_pat = 3'b110;
      COL1:    col_pat = 3'b101;
      default: col_pat = 3'b011;
    endcase
  end

  assign col_out = run_q ? col_pat : 3'b111;

  // Frame decode: the COL2 rows are taken live from the synchroniser on the
  // sampling cycle, the other two columns from their captured slots.
  always_comb begin
    act = '0;
    for (int r = 0; r < 4; r++) begin
      act[r*3 + 0] = hit0_q[r];
      act[r*3 + 1] = hit1_q[r];
      act[r*3 + 2] = ~row_s2_q[r];
    end
    n_act      = '0;
    frame_code = NOKEY;
    for (int i = 0; i < 12; i++) begin
      if (act[i]) n_act = n_act + 1'b1;
    end
    if (n_act == 4'd1) begin
      for (int i = 0; i < 12; i++) begin
        if (act[i]) frame_code = digit_of(4'(i));
      end
    end
  end

  always_comb begin
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    if (frame_end) begin
      if (frame_code == cand_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cand_d = frame_code;
        cnt_d  = CNT_W'(1);
      end
      // Any qualified change of code is accepted, digit-to-digit included;
      // only a change to a digit is announced.
      if ((cnt_d == CNT_MAX) && (cand_d != key_q)) begin
        key_d       = cand_d;
        key_valid_d = (cand_d != NOKEY);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      run_q       <= 1'b0;
      state_q     <= COL0;
      settle_q    <= '0;
      hit0_q      <= '0;
      hit1_q      <= '0;
      cand_q      <= NOKEY;
      cnt_q       <= '0;
      key_q       <= NOKEY;
      key_valid_q <= 1'b0;
    end else begin
      row_s1_q    <= row_in;
      row_s2_q    <= row_s1_q;
      run_q       <= 1'b1;
      state_q     <= state_d;
      settle_q    <= settle_d;
      if (slot_end && (state_q == COL0)) hit0_q <= ~row_s2_q;
      if (slot_end && (state_q == COL1)) hit1_q <= ~row_s2_q;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;

endmodule
